// File: rtl/multi_edge_detector.sv
// multi_edge_detector
//   Multi-channel edge detector for asynchronous board-level inputs.
//   Each channel has a synchroniser chain, an optional debounce filter and a
//   per-channel edge mode. Detected edges are reported as one-cycle pulses,
//   latched into write-1-to-clear sticky flags, combined into a masked
//   interrupt and counted by a saturating event counter.
//
//   Optional feature: define MULTI_EDGE_DETECTOR_DEBOUNCE_EN to insert a
//   per-channel debounce filter of DEBOUNCE_CYCLES stable cycles between the
//   synchroniser and the edge detector. Without it, DEBOUNCE_CYCLES is unused
//   apart from its legality check.
//
//   Reset is synchronous and active-high (RESET sampled on the rising CLK edge).

module multi_edge_detector #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int CNT_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   ENABLE,
    input  logic [WIDTH-1:0]       SIGNAL,
    input  logic [2*WIDTH-1:0]     MODE,
    input  logic [WIDTH-1:0]       FLAG_CLEAR,
    input  logic [WIDTH-1:0]       IRQ_MASK,
    input  logic                   COUNT_CLEAR,
    output logic [WIDTH-1:0]       RISING_EDGE,
    output logic [WIDTH-1:0]       FALLING_EDGE,
    output logic [WIDTH-1:0]       FLAGS,
    output logic                   IRQ,
    output logic [CNT_WIDTH-1:0]   EVENT_COUNT,
    output logic [WIDTH-1:0]       LEVEL
);

    // ------------------------------------------------------------------
    // Parameter legality, caught at elaboration time
    // ------------------------------------------------------------------
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("multi_edge_detector: SYNC_STAGES must be in the range 2..4");
    end

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce_cycles
        $error("multi_edge_detector: DEBOUNCE_CYCLES must be at least 2");
    end

    if (WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_widths
        $error("multi_edge_detector: WIDTH and CNT_WIDTH must be at least 1");
    end

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    localparam logic [CNT_WIDTH-1:0] COUNT_MAX = {CNT_WIDTH{1'b1}};

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  synced;     // last synchroniser stage
    logic [WIDTH-1:0]                  cur;        // level fed to the detector
    logic [WIDTH-1:0]                  prev_q, prev_d;
    logic [WIDTH-1:0]                  mode_rise, mode_fall;
    logic [WIDTH-1:0]                  rise_edge, fall_edge;
    logic                              any_edge;
    logic [WIDTH-1:0]                  flags_q, flags_d;
    logic [CNT_WIDTH-1:0]              count_q, count_d;

    // ------------------------------------------------------------------
    // Synchroniser chain: stage 0 samples the raw input, each later stage
    // re-samples the one before it. Runs regardless of ENABLE.
    // ------------------------------------------------------------------

    // Next state of the synchroniser shift register
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sync_d    = sync_q;
        sync_d[0] = SIGNAL;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Synchroniser flops, cleared by reset
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values of its sources, as real hardware does.
        if (RESET) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef MULTI_EDGE_DETECTOR_DEBOUNCE_EN
    // ------------------------------------------------------------------
    // Debounce filter: the filtered level only follows the synchronised
    // input after it has differed for DEBOUNCE_CYCLES consecutive cycles.
    // Any return to agreement restarts the count, so shorter pulses vanish.
    // ------------------------------------------------------------------
    localparam int                    DB_CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_CNT_W-1:0]   DB_LAST  = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0][DB_CNT_W-1:0]   db_cnt_q, db_cnt_d;
    logic [WIDTH-1:0]                 level_q, level_d;

    // Per-channel debounce counter and filtered-level update
    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (synced[i] == level_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                level_d[i]  = synced[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_CNT_W'(1);
            end
        end
    end

    // Debounce counters and filtered level, cleared by reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            db_cnt_q <= '0;
            level_q  <= '0;
        end else begin
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
        end
    end

    assign cur = level_q;
`else
    // Without the filter the detector watches the synchroniser output directly
    assign cur = synced;
`endif

    // ------------------------------------------------------------------
    // Edge detection. prev tracks cur every cycle, independent of ENABLE,
    // so re-enabling never reports an edge that happened while disabled.
    // ------------------------------------------------------------------
    assign prev_d = cur;

    // Delayed copy of the detector input
    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    // Split the packed 2-bit-per-channel mode field into rise/fall enables
    always_comb begin
        mode_rise = '0;
        mode_fall = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mode_rise[i] = MODE[2*i];
            mode_fall[i] = MODE[2*i+1];
        end
    end

    // Mode changes act combinationally on whatever edge is sitting in cur/prev
    assign rise_edge = {WIDTH{ENABLE}} & cur    & ~prev_q & mode_rise;
    assign fall_edge = {WIDTH{ENABLE}} & ~cur   &  prev_q & mode_fall;
    assign any_edge  = |(rise_edge | fall_edge);

    // ------------------------------------------------------------------
    // Sticky flags: clear first, then OR in new events, so a set arriving
    // in the same cycle as its clear strobe keeps the flag at 1.
    // ------------------------------------------------------------------

    // Next state of the sticky flags
    always_comb begin
        flags_d = (flags_q & ~FLAG_CLEAR) | rise_edge | fall_edge;
    end

    // Sticky flag register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    // ------------------------------------------------------------------
    // Event counter: one increment per cycle with any pulse, however many
    // channels fire. Clear beats increment; the count holds at its maximum.
    // ------------------------------------------------------------------

    // Next state of the saturating event counter
    always_comb begin
        count_d = count_q;
        if (COUNT_CLEAR) begin
            count_d = '0;
        end else if (any_edge && (count_q != COUNT_MAX)) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    // Event counter register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign RISING_EDGE  = rise_edge;
    assign FALLING_EDGE = fall_edge;
    assign FLAGS        = flags_q;
    assign IRQ          = |(flags_q & IRQ_MASK);
    assign EVENT_COUNT  = count_q;
    assign LEVEL        = cur;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed testbench for multi_edge_detector (WIDTH=4, SYNC_STAGES=2,
// CNT_WIDTH=3 so saturation is reachable quickly). Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge.
// When MULTI_EDGE_DETECTOR_DEBOUNCE_EN is defined the expected latency grows
// by DEBOUNCE_CYCLES and the glitch-rejection scenario replaces the
// single-cycle-pulse scenario.

module tb_multi_edge_detector;

    localparam int W  = 4;
    localparam int SS = 2;
    localparam int CW = 3;
    localparam int DB = 4;
`ifdef MULTI_EDGE_DETECTOR_DEBOUNCE_EN
    localparam int EXTRA = DB;
`else
    localparam int EXTRA = 0;
`endif
    // Edges from "input changed" until the pulse is visible
    localparam int LAT = SS + EXTRA;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            ENABLE;
    logic [W-1:0]    SIGNAL;
    logic [2*W-1:0]  MODE;
    logic [W-1:0]    FLAG_CLEAR;
    logic [W-1:0]    IRQ_MASK;
    logic            COUNT_CLEAR;
    logic [W-1:0]    RISING_EDGE;
    logic [W-1:0]    FALLING_EDGE;
    logic [W-1:0]    FLAGS;
    logic            IRQ;
    logic [CW-1:0]   EVENT_COUNT;
    logic [W-1:0]    LEVEL;

    int n_checks = 0;
    int n_fail   = 0;

    multi_edge_detector #(
        .WIDTH           (W),
        .SYNC_STAGES     (SS),
        .CNT_WIDTH       (CW),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ENABLE       (ENABLE),
        .SIGNAL       (SIGNAL),
        .MODE         (MODE),
        .FLAG_CLEAR   (FLAG_CLEAR),
        .IRQ_MASK     (IRQ_MASK),
        .COUNT_CLEAR  (COUNT_CLEAR),
        .RISING_EDGE  (RISING_EDGE),
        .FALLING_EDGE (FALLING_EDGE),
        .FLAGS        (FLAGS),
        .IRQ          (IRQ),
        .EVENT_COUNT  (EVENT_COUNT),
        .LEVEL        (LEVEL)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    // Reset state, and reset priority over a high input
    task automatic test_reset();
        RESET       = 1'b1;
        ENABLE      = 1'b1;
        MODE        = 8'hFF;
        SIGNAL      = 4'hF;
        FLAG_CLEAR  = '0;
        IRQ_MASK    = '0;
        COUNT_CLEAR = 1'b0;
        tick_n(4);
        SIGNAL = 4'h0;
        tick_n(2);
        n_checks++;
        if (RISING_EDGE !== 4'b0000) begin
            n_fail++; $display("FAIL reset_rise: got %b expected %b", RISING_EDGE, 4'b0000);
        end
        n_checks++;
        if (FALLING_EDGE !== 4'b0000) begin
            n_fail++; $display("FAIL reset_fall: got %b expected %b", FALLING_EDGE, 4'b0000);
        end
        n_checks++;
        if (FLAGS !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected %b", FLAGS, 4'b0000);
        end
        n_checks++;
        if (IRQ !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq: got %b expected 0", IRQ);
        end
        n_checks++;
        if (LEVEL !== 4'b0000) begin
            n_fail++; $display("FAIL reset_level: got %b expected %b", LEVEL, 4'b0000);
        end
        n_checks++;
        if (EVENT_COUNT !== 3'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d expected 0", EVENT_COUNT);
        end
    endtask

    // Release reset and raise channel 2: pulse latency, width, flag, count
    task automatic test_first_edge();
        int extra_rises;
        RESET     = 1'b0;
        SIGNAL[2] = 1'b1;
        tick_n(LAT - 1);
        n_checks++;
        if (RISING_EDGE !== 4'b0000) begin
            n_fail++; $display("FAIL first_early: got %b expected %b", RISING_EDGE, 4'b0000);
        end
        tick();
        n_checks++;
        if (RISING_EDGE !== 4'b0100) begin
            n_fail++; $display("FAIL first_pulse: got %b expected %b", RISING_EDGE, 4'b0100);
        end
        n_checks++;
        if (FLAGS !== 4'b0000) begin
            n_fail++; $display("FAIL first_flags_early: got %b expected %b", FLAGS, 4'b0000);
        end
        tick();
        n_checks++;
        if (RISING_EDGE !== 4'b0000) begin
            n_fail++; $display("FAIL first_pulse_width: got %b expected %b", RISING_EDGE, 4'b0000);
        end
        n_checks++;
        if (FLAGS !== 4'b0100) begin
            n_fail++; $display("FAIL first_flags: got %b expected %b", FLAGS, 4'b0100);
        end
        n_checks++;
        if (EVENT_COUNT !== 3'd1) begin
            n_fail++; $display("FAIL first_count: got %0d expected 1", EVENT_COUNT);
        end
        n_checks++;
        if (LEVEL !== 4'b0100) begin
            n_fail++; $display("FAIL first_level: got %b expected %b", LEVEL, 4'b0100);
        end
        // Held input never pulses again
        extra_rises = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (RISING_EDGE != 4'b0000) extra_rises++;
        end
        n_checks++;
        if (extra_rises !== 0) begin
            n_fail++; $display("FAIL held_no_repulse: got %0d pulses expected 0", extra_rises);
        end
        FLAG_CLEAR = 4'hF;
        tick();
        FLAG_CLEAR = 4'h0;
        n_checks++;
        if (FLAGS !== 4'b0000) begin
            n_fail++; $display("FAIL first_clear: got %b expected %b", FLAGS, 4'b0000);
        end
    endtask

    // Channel 0 in falling-only mode, IRQ masking and write-1-to-clear
    task automatic test_falling_mode();
        int rises;
        int falls;
        MODE     = 8'hFE;
        IRQ_MASK = 4'b0001;
        rises    = 0;
        falls    = 0;
        SIGNAL[0] = 1'b1;
        for (int j = 0; j < 8 + EXTRA; j++) begin
            tick();
            if (RISING_EDGE[0])  rises++;
            if (FALLING_EDGE[0]) falls++;
        end
        SIGNAL[0] = 1'b0;
        for (int j = 0; j < 8 + EXTRA; j++) begin
            tick();
            if (RISING_EDGE[0])  rises++;
            if (FALLING_EDGE[0]) falls++;
        end
        n_checks++;
        if (rises !== 0) begin
            n_fail++; $display("FAIL fall_mode_rises: got %0d expected 0", rises);
        end
        n_checks++;
        if (falls !== 1) begin
            n_fail++; $display("FAIL fall_mode_falls: got %0d expected 1", falls);
        end
        n_checks++;
        if (FLAGS !== 4'b0001) begin
            n_fail++; $display("FAIL fall_mode_flags: got %b expected %b", FLAGS, 4'b0001);
        end
        n_checks++;
        if (IRQ !== 1'b1) begin
            n_fail++; $display("FAIL irq_set: got %b expected 1", IRQ);
        end
        IRQ_MASK = 4'b1110;
        #1;
        n_checks++;
        if (IRQ !== 1'b0) begin
            n_fail++; $display("FAIL irq_masked: got %b expected 0", IRQ);
        end
        IRQ_MASK = 4'b0001;
        #1;
        FLAG_CLEAR = 4'b0001;
        tick();
        FLAG_CLEAR = 4'b0000;
        n_checks++;
        if (IRQ !== 1'b0) begin
            n_fail++; $display("FAIL irq_cleared: got %b expected 0", IRQ);
        end
        n_checks++;
        if (FLAGS !== 4'b0000) begin
            n_fail++; $display("FAIL fall_mode_clear: got %b expected %b", FLAGS, 4'b0000);
        end
    endtask

    // Clear strobe on the same cycle as a pulse: the set wins
    task automatic test_set_wins();
        MODE      = 8'hFF;
        IRQ_MASK  = 4'b0000;
        SIGNAL[1] = 1'b1;
        tick_n(LAT);
        n_checks++;
        if (RISING_EDGE !== 4'b0010) begin
            n_fail++; $display("FAIL set_wins_pulse: got %b expected %b", RISING_EDGE, 4'b0010);
        end
        FLAG_CLEAR = 4'b0010;
        tick();
        FLAG_CLEAR = 4'b0000;
        n_checks++;
        if (FLAGS !== 4'b0010) begin
            n_fail++; $display("FAIL set_wins_flag: got %b expected %b", FLAGS, 4'b0010);
        end
    endtask

    // Disabled: no pulses, level still tracks, clear still works, no stale edge
    task automatic test_enable();
        int pulses;
        ENABLE    = 1'b0;
        SIGNAL[3] = 1'b1;
        SIGNAL[1] = 1'b0;
        pulses    = 0;
        for (int j = 0; j < LAT + 5; j++) begin
            tick();
            if ((RISING_EDGE | FALLING_EDGE) != 4'b0000) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL disabled_pulses: got %0d expected 0", pulses);
        end
        n_checks++;
        if (FLAGS !== 4'b0010) begin
            n_fail++; $display("FAIL disabled_flags: got %b expected %b", FLAGS, 4'b0010);
        end
        n_checks++;
        if (LEVEL !== 4'b1100) begin
            n_fail++; $display("FAIL disabled_level: got %b expected %b", LEVEL, 4'b1100);
        end
        FLAG_CLEAR = 4'b0010;
        tick();
        FLAG_CLEAR = 4'b0000;
        n_checks++;
        if (FLAGS !== 4'b0000) begin
            n_fail++; $display("FAIL disabled_clear: got %b expected %b", FLAGS, 4'b0000);
        end
        ENABLE = 1'b1;
        #1;
        pulses = 0;
        if ((RISING_EDGE | FALLING_EDGE) != 4'b0000) pulses++;
        for (int j = 0; j < 3; j++) begin
            tick();
            if ((RISING_EDGE | FALLING_EDGE) != 4'b0000) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL reenable_stale: got %0d pulses expected 0", pulses);
        end
        n_checks++;
        if (FLAGS !== 4'b0000) begin
            n_fail++; $display("FAIL reenable_flags: got %b expected %b", FLAGS, 4'b0000);
        end
    endtask

    // Event counter: multi-channel cycle counts once, saturation, clear priority
    task automatic test_count();
        int exp;
        MODE        = 8'hFF;
        COUNT_CLEAR = 1'b1;
        tick();
        COUNT_CLEAR = 1'b0;
        n_checks++;
        if (EVENT_COUNT !== 3'd0) begin
            n_fail++; $display("FAIL count_clear_idle: got %0d expected 0", EVENT_COUNT);
        end
        SIGNAL[1:0] = 2'b11;
        tick_n(LAT);
        n_checks++;
        if (RISING_EDGE !== 4'b0011) begin
            n_fail++; $display("FAIL count_two_channels: got %b expected %b", RISING_EDGE, 4'b0011);
        end
        tick();
        n_checks++;
        if (EVENT_COUNT !== 3'd1) begin
            n_fail++; $display("FAIL count_one_per_cycle: got %0d expected 1", EVENT_COUNT);
        end
        for (int i = 0; i < 9; i++) begin
            SIGNAL[0] = ~SIGNAL[0];
            tick_n(LAT + 2);
            exp = (i + 2 > 7) ? 7 : i + 2;
            n_checks++;
            if (EVENT_COUNT !== CW'(exp)) begin
                n_fail++; $display("FAIL count_step%0d: got %0d expected %0d", i, EVENT_COUNT, exp);
            end
        end
        SIGNAL[0] = ~SIGNAL[0];
        tick_n(LAT);
        n_checks++;
        if (RISING_EDGE !== 4'b0001) begin
            n_fail++; $display("FAIL count_clear_edge_pulse: got %b expected %b", RISING_EDGE, 4'b0001);
        end
        COUNT_CLEAR = 1'b1;
        tick();
        COUNT_CLEAR = 1'b0;
        n_checks++;
        if (EVENT_COUNT !== 3'd0) begin
            n_fail++; $display("FAIL count_clear_priority: got %0d expected 0", EVENT_COUNT);
        end
        tick_n(3);
        n_checks++;
        if (EVENT_COUNT !== 3'd0) begin
            n_fail++; $display("FAIL count_clear_hold: got %0d expected 0", EVENT_COUNT);
        end
    endtask

    // Narrow pulses: passed back to back without the filter, rejected with it
    task automatic test_narrow_pulse();
        int rises;
        int falls;
        int rise_j;
        int fall_j;
        SIGNAL = 4'h0;
        tick_n(LAT + 4);
        FLAG_CLEAR = 4'hF;
        tick();
        FLAG_CLEAR = 4'h0;
        rises  = 0;
        falls  = 0;
        rise_j = -1;
        fall_j = -1;
`ifdef MULTI_EDGE_DETECTOR_DEBOUNCE_EN
        SIGNAL[0] = 1'b1;
        tick_n(3);
        SIGNAL[0] = 1'b0;
        for (int j = 0; j < 16; j++) begin
            tick();
            if (RISING_EDGE[0]) rises++;
        end
        n_checks++;
        if (rises !== 0) begin
            n_fail++; $display("FAIL glitch_rejected: got %0d pulses expected 0", rises);
        end
        n_checks++;
        if (LEVEL[0] !== 1'b0) begin
            n_fail++; $display("FAIL glitch_level: got %b expected 0", LEVEL[0]);
        end
        SIGNAL[0] = 1'b1;
        for (int j = 1; j <= 24; j++) begin
            tick();
            if (j == 6) SIGNAL[0] = 1'b0;
            if (RISING_EDGE[0]) begin
                rises++;
                if (rise_j < 0) rise_j = j;
            end
            if (FALLING_EDGE[0]) falls++;
        end
        n_checks++;
        if (rises !== 1) begin
            n_fail++; $display("FAIL debounce_rises: got %0d expected 1", rises);
        end
        n_checks++;
        if (rise_j !== LAT) begin
            n_fail++; $display("FAIL debounce_latency: got %0d expected %0d", rise_j, LAT);
        end
        n_checks++;
        if (falls !== 1) begin
            n_fail++; $display("FAIL debounce_falls: got %0d expected 1", falls);
        end
`else
        SIGNAL[0] = 1'b1;
        tick();
        SIGNAL[0] = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (RISING_EDGE[0]) begin
                rises++;
                rise_j = j;
            end
            if (FALLING_EDGE[0]) begin
                falls++;
                fall_j = j;
            end
        end
        n_checks++;
        if (rises !== 1) begin
            n_fail++; $display("FAIL narrow_rises: got %0d expected 1", rises);
        end
        n_checks++;
        if (falls !== 1) begin
            n_fail++; $display("FAIL narrow_falls: got %0d expected 1", falls);
        end
        n_checks++;
        if (fall_j !== rise_j + 1) begin
            n_fail++; $display("FAIL back_to_back: got fall at %0d rise at %0d expected consecutive", fall_j, rise_j);
        end
`endif
        n_checks++;
        if (FLAGS !== 4'b0001) begin
            n_fail++; $display("FAIL narrow_flags: got %b expected %b", FLAGS, 4'b0001);
        end
    endtask

    initial begin
        test_reset();
        test_first_edge();
        test_falling_mode();
        test_set_wins();
        test_enable();
        test_count();
        test_narrow_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
- Parametrised, multi-channel edge detector.
- Each channel has an input synchroniser and a per-channel edge mode select.
- Detected edges appear as single-cycle pulses and also set sticky flags, which are cleared by write-1-to-clear.
- Provides a masked interrupt output and a saturating event counter; sits between asynchronous board inputs (buttons, GPIO, status lines) and the bus-side register block.

Parameters:
- WIDTH, 8, number of independent input channels.
- SYNC_STAGES, 2, synchroniser flops per channel; legal range 2..4.
- CNT_WIDTH, 16, width of the saturating event counter.
- DEBOUNCE_CYCLES, 4, stable-cycle count for the debounce filter; used only with DEBOUNCE_EN; legal range >= 2.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- ENABLE  input  1  global enable; when 0, no edges are reported.
- SIGNAL  input  WIDTH  asynchronous inputs being watched.
- MODE  input  2*WIDTH  per-channel mode in MODE[2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- FLAG_CLEAR  input  WIDTH  write-1-to-clear strobe for FLAGS; single-cycle.
- IRQ_MASK  input  WIDTH  1 = channel contributes to IRQ.
- COUNT_CLEAR  input  1  zeroes EVENT_COUNT.
- RISING_EDGE  output  WIDTH  one-cycle pulse per detected rising edge (mode-gated).
- FALLING_EDGE  output  WIDTH  one-cycle pulse per detected falling edge (mode-gated).
- FLAGS  output  WIDTH  sticky event flags, registered.
- IRQ  output  1  OR of (FLAGS & IRQ_MASK), combinational from registers.
- EVENT_COUNT  output  CNT_WIDTH  number of cycles in which any edge pulse was asserted; saturates.
- LEVEL  output  WIDTH  synchronised (and filtered, when debounce is enabled) input level.

Behaviour:
- Reset, RESET=1 at a rising CLK edge: sync chain, filtered level, prev register, FLAGS, EVENT_COUNT and debounce counters all go to 0.
  - Consequently RISING_EDGE, FALLING_EDGE, IRQ and LEVEL read 0 in the cycle after reset.
  - RESET has priority over all other inputs.
- Per-channel pipeline:
  - sync[0] <= SIGNAL[i]; sync[k] <= sync[k-1]; cur = sync[SYNC_STAGES-1] (or the filtered value); prev <= cur every cycle.
  - Synchronisers and prev run regardless of ENABLE, so re-enabling never reports a stale edge.
- Edge pulses, combinational from registers:
  - RISING_EDGE[i] = ENABLE & cur & ~prev & MODE[2i].
  - FALLING_EDGE[i] = ENABLE & ~cur & prev & MODE[2i+1].
- Latency: a SIGNAL change that is stable before edge k produces a pulse high for exactly the one cycle between edges k+SYNC_STAGES-1 and k+SYNC_STAGES.
- Pulse rules:
  - An input held constant never produces a second pulse.
  - A glitch shorter than one clock may be missed; no other input is missed.
- FLAGS[i]:
  - Set at the edge ending a pulse cycle: FLAGS <= (FLAGS & ~FLAG_CLEAR) | RISING_EDGE | FALLING_EDGE.
  - Simultaneous set and clear on the same channel: set wins, so the flag stays 1.
  - Clearing works while ENABLE=0.
- IRQ asserts in the same cycle FLAGS becomes visible and deasserts the cycle after the masked flags clear. Changing IRQ_MASK affects IRQ immediately, since IRQ is combinational.
- EVENT_COUNT:
  - Increments by 1 on any cycle where |(RISING_EDGE|FALLING_EDGE) is true, regardless of how many channels fire.
  - Holds at 2^CNT_WIDTH-1 (saturates, no wrap).
  - COUNT_CLEAR has priority over an increment in the same cycle: result is 0.
- MODE change mid-stream: takes effect combinationally; an edge already in prev/cur is reported only if the new mode permits it.
- Inputs already high when reset releases produce a rising edge after SYNC_STAGES cycles. This is intentional, since the power-on level is unknown; software clears it.

Optional Feature:
- Macro: MULTI_EDGE_DETECTOR_DEBOUNCE_EN.
- When defined:
  - Each channel gets a counter that increments while sync[SYNC_STAGES-1] differs from the filtered level.
  - The counter resets to 0 whenever the two are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and they still differ, the filtered level takes the synced value and the counter resets.
  - Adds exactly DEBOUNCE_CYCLES cycles of latency; pulses narrower than DEBOUNCE_CYCLES synced cycles are rejected.
- When undefined: cur = sync[SYNC_STAGES-1]; no counters are instantiated; DEBOUNCE_CYCLES is ignored.

Test Plan:
- Reset release with WIDTH=4, MODE=8'hFF, ENABLE=1, SIGNAL=4'b0000; raise SIGNAL[2] before edge 10 -> RISING_EDGE=4'b0100 only in the cycle after edge 11; FLAGS=4'b0100 from edge 12; EVENT_COUNT=1.
- MODE[1:0]=10, toggle SIGNAL[0] 0->1->0 with 5-cycle spacing -> no RISING_EDGE; one FALLING_EDGE[0] pulse; FLAGS[0]=1. With IRQ_MASK=4'b0001, IRQ=1; FLAG_CLEAR=4'b0001 -> IRQ=0 next cycle.
- FLAG_CLEAR[1]=1 in the same cycle as a pulse on channel 1 -> FLAGS[1] remains 1.
- ENABLE=0, SIGNAL[3] rises, wait 5 cycles, ENABLE=1 -> no pulse, FLAGS unchanged, LEVEL[3]=1.
- CNT_WIDTH=3, generate 10 edge cycles -> EVENT_COUNT stops at 7. COUNT_CLEAR together with an edge cycle -> EVENT_COUNT=0.
- With MULTI_EDGE_DETECTOR_DEBOUNCE_EN and DEBOUNCE_CYCLES=4:
  - 3-cycle high glitch on SIGNAL[0] -> no pulse, LEVEL[0]=0.
  - 6-cycle high pulse -> one RISING_EDGE[0] exactly 4 cycles later than in the non-debounced build.
